// File: rtl/mul_seq_32_if.sv
// Bundle for the sequential multiplier: issue-side start/busy/done plus the
// shared-adder operand/sum path.
interface mul_seq_32_if #(
  parameter int WIDTH = 32
);
  // start is taken only when busy=0 (IDLE or DONE); done pulses one cycle with
  // result valid, and result stays put until the next accepted start.
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_s;
  logic               add_cout;
  logic [2:0]         dbg_state;

  modport slave (
    input  start, sgn, op_a, op_b, add_s, add_cout,
    output busy, done, result, add_a, add_b, add_cin, dbg_state
  );

  modport master (
    output start, sgn, op_a, op_b, add_s, add_cout,
    input  busy, done, result, add_a, add_b, add_cin, dbg_state
  );
endinterface

// File: rtl/mul_seq_32.sv
// Iterative shift-and-add multiplier that borrows an external WIDTH-bit adder
// every cycle; signed operands are handled by magnitude conversion and fixup.
module mul_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_seq_32_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NEGA = 3'd1,
    NEGB = 3'd2,
    MUL  = 3'd3,
    NEGL = 3'd4,
    NEGH = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             neg, neg_nxt;
  logic             nb, nb_nxt;
  logic             c, c_nxt;
  logic             busy_r, done_r;
  logic [2*WIDTH-1:0] result_r;

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.dbg_state = state;

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_reg;
    hi_nxt      = hi;
    lo_nxt      = lo;
    cnt_nxt     = cnt;
    neg_nxt     = neg;
    nb_nxt      = nb;
    c_nxt       = c;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          a_nxt   = bus.op_a;
          lo_nxt  = bus.op_b;
          hi_nxt  = '0;
          cnt_nxt = '0;
          neg_nxt = bus.sgn & (bus.op_a[MSB] ^ bus.op_b[MSB]);
          nb_nxt  = bus.sgn & bus.op_b[MSB];
          if (bus.sgn && bus.op_a[MSB])      state_nxt = NEGA;
          else if (bus.sgn && bus.op_b[MSB]) state_nxt = NEGB;
          else                               state_nxt = MUL;
        end else begin
          state_nxt = IDLE;
        end
      end
      NEGA: begin
        bus.add_a   = ~a_reg;
        bus.add_cin = 1'b1;
        a_nxt       = bus.add_s;
        state_nxt   = nb ? NEGB : MUL;
      end
      NEGB: begin
        bus.add_a   = ~lo;
        bus.add_cin = 1'b1;
        lo_nxt      = bus.add_s;
        state_nxt   = MUL;
      end
      MUL: begin
        // The adder carry becomes the new top bit as the pair shifts right.
        bus.add_a = hi;
        bus.add_b = lo[0] ? a_reg : '0;
        hi_nxt    = {bus.add_cout, bus.add_s[MSB:1]};
        lo_nxt    = {bus.add_s[0], lo[MSB:1]};
        cnt_nxt   = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) state_nxt = neg ? NEGL : DONE;
      end
      NEGL: begin
        bus.add_a   = ~lo;
        bus.add_cin = 1'b1;
        lo_nxt      = bus.add_s;
        c_nxt       = bus.add_cout;
        state_nxt   = NEGH;
      end
      NEGH: begin
        bus.add_a   = ~hi;
        bus.add_cin = c;
        hi_nxt      = bus.add_s;
        state_nxt   = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      nb       <= 1'b0;
      c        <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      cnt    <= cnt_nxt;
      neg    <= neg_nxt;
      nb     <= nb_nxt;
      c      <= c_nxt;
      busy_r <= (state_nxt != IDLE) && (state_nxt != DONE);
      done_r <= (state_nxt == DONE);
      // DONE is only ever entered from a busy state, so this loads once per op.
      if (state_nxt == DONE) result_r <= {hi_nxt, lo_nxt};
    end
  end
endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: vector table plus directed sequences for
// reset abort, back-to-back starts and starts issued while busy.
module tb_mul_seq_32;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   last_busy;

  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];

  mul_seq_32_if #(.WIDTH(W)) bus ();

  mul_seq_32 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural stand-in for the shared cla_32 adder.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             lat;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [2*W-1:0] model_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    if (s) begin
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      return 64'(sa * sb);
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic int model_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int l;
    l = 33;
    if (s && a[W-1]) l += 1;
    if (s && b[W-1]) l += 1;
    if (s && (a[W-1] ^ b[W-1])) l += 2;
    return l;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Called #1 after a clock edge; start is high for exactly one edge.
  task automatic drive_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] e, input int l);
    bus.sgn   = s;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(l);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Entered in cycle 1 of an op; returns #1 into the done cycle.
  task automatic wait_check(input string name);
    int lat;
    logic [2*W-1:0] e;
    int el;
    lat = 1;
    last_busy = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) last_busy++;
      @(posedge clk);
      #1;
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    if (!bus.done) begin
      check({name, "_timeout"}, 64'(bus.done), 64'd1);
    end else begin
      check({name, "_result"}, bus.result, e);
      check({name, "_latency"}, 64'(lat), 64'(el));
      check({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    logic [2*W-1:0] held;
    logic           seen;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 36};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 35};
    vecs[3]  = '{1'b0, 32'h00000000, 32'h00000000, 64'h0, 33};
    vecs[4]  = '{1'b0, 32'h00001234, 32'h00005678, 64'h06260060, 33};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 35};
    for (int i = 6; i < 14; i++) begin
      vecs[i].sgn = 1'($urandom_range(0, 1));
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      if (i == 6) begin vecs[i].sgn = 1'b1; vecs[i].a = 32'h7FFFFFFF; vecs[i].b = 32'h80000000; end
      vecs[i].exp = model_mul(vecs[i].sgn, vecs[i].a, vecs[i].b);
      vecs[i].lat = model_lat(vecs[i].sgn, vecs[i].a, vecs[i].b);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_result", bus.result, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_add_bus", {bus.add_a, bus.add_b[W-2:0], bus.add_cin}, 64'd0);
    check("idle_state", 64'(bus.dbg_state), 64'd0);

    // Vector table; odd entries leave a few idle cycles, even ones go back-to-back.
    for (int i = 0; i < 14; i++) begin
      drive_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      wait_check($sformatf("vec%0d", i));
      if (i == 0) check("umax_busy_cycles", 64'(last_busy), 64'd32);
      if (i % 2 == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    check("done_is_pulse", 64'(bus.done), 64'd0);

    // Signed zero with fixup, then a start right in its DONE cycle.
    drive_op(1'b1, 32'h0, 32'hFFFFFFFF, 64'h0, 36);
    wait_check("szero");
    drive_op(1'b0, 32'd7, 32'd6, 64'h2A, 33);
    wait_check("b2b");
    held = bus.result;
    repeat (4) @(posedge clk);
    #1;
    check("result_held", bus.result, held);
    check("idle_after_done", 64'(bus.dbg_state), 64'd0);

    // Reset in cycle 10 aborts the op and clears outputs.
    drive_op(1'b0, 32'h1234, 32'h5678, 64'h06260060, 33);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", bus.result, 64'd0);
    check("abort_add_a", 64'(bus.add_a), 64'd0);
    check("abort_add_b_cin", {bus.add_b, bus.add_cin}, 64'd0);
    drive_op(1'b0, 32'h1234, 32'h5678, 64'h06260060, 33);
    wait_check("after_abort");

    // A start while busy must be dropped without queuing.
    @(posedge clk);
    #1;
    drive_op(1'b0, 32'd1000, 32'd3000, 64'd3000000, 33);
    repeat (4) @(posedge clk);
    #1;
    bus.sgn   = 1'b1;
    bus.op_a  = 32'hDEADBEEF;
    bus.op_b  = 32'h12345678;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    begin
      int lat;
      lat = 6;
      while (!bus.done && lat < 64) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("ignored_start_result", bus.result, exp_q.pop_front());
      check("ignored_start_latency", 64'(lat), 64'(lat_q.pop_front()));
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("no_second_done", 64'(seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
